// File: rtl/debounce_bank.sv
// debounce_bank: multi-channel input debouncer.
// Each channel synchronises its raw input and runs a stability counter.
// A new value is accepted only after it has held for STABLE_COUNT consecutive
// synchronised cycles. Accepted changes update the clean level and produce
// registered one-cycle rise/fall pulses. Edges on enabled channels latch
// pending bits, which are ORed into a registered interrupt request that
// software clears with a one-cycle int_ack pulse.
// The interrupt output is named int_req because "int" is a reserved word.
module debounce_bank #(
    parameter int CHANNELS     = 8,
    parameter int SYNC_STAGES  = 2,
    parameter int COUNT_WIDTH  = 20,
    parameter int STABLE_COUNT = 500000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] raw,
    input  logic [CHANNELS-1:0] int_mask,
    input  logic                int_ack,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic [CHANNELS-1:0] pending,
    output logic                int_req
);

    // Terminal count: reaching it while sync still differs accepts the value.
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(STABLE_COUNT - 1);

    // Synchroniser chain, stage 0 samples raw, last stage feeds the counters.
    logic [CHANNELS-1:0]    sync_r [SYNC_STAGES];
    logic [CHANNELS-1:0]    sync_s;

    // Per-channel stability state.
    logic [COUNT_WIDTH-1:0] cnt_r     [CHANNELS];
    logic [COUNT_WIDTH-1:0] cnt_nxt_s [CHANNELS];
    logic [CHANNELS-1:0]    level_r;
    logic [CHANNELS-1:0]    level_nxt_s;
    logic [CHANNELS-1:0]    rise_r;
    logic [CHANNELS-1:0]    rise_nxt_s;
    logic [CHANNELS-1:0]    fall_r;
    logic [CHANNELS-1:0]    fall_nxt_s;

    // Interrupt bookkeeping.
    logic [CHANNELS-1:0]    pending_r;
    logic [CHANNELS-1:0]    pending_nxt_s;
    logic                   int_r;

    assign sync_s = sync_r[SYNC_STAGES-1];

    // Shift raw inputs through the synchroniser flops; reset clears every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= '0;
            end
        end else begin
            sync_r[0] <= raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Counter/level decision per channel; a bounce back to the current level
    // discards any partial count.
    always_comb begin
        level_nxt_s = level_r;
        rise_nxt_s  = '0;
        fall_nxt_s  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (sync_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = '0;
            end else if (cnt_r[i] == LAST_COUNT) begin
                cnt_nxt_s[i]   = '0;
                level_nxt_s[i] = sync_s[i];
                rise_nxt_s[i]  = sync_s[i];
                fall_nxt_s[i]  = ~sync_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + COUNT_WIDTH'(1);
            end
        end
    end

    // Pending bits: a new edge on an enabled channel wins over a same-cycle ack.
    always_comb begin
        pending_nxt_s = (pending_r & ~{CHANNELS{int_ack}}) | ((rise_r | fall_r) & int_mask);
    end

    // Register counters, level, edge pulses and pending/interrupt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= '0;
            end
            level_r   <= '0;
            rise_r    <= '0;
            fall_r    <= '0;
            pending_r <= '0;
            int_r     <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
            level_r   <= level_nxt_s;
            rise_r    <= rise_nxt_s;
            fall_r    <= fall_nxt_s;
            pending_r <= pending_nxt_s;
            int_r     <= |pending_nxt_s;
        end
    end

    assign level   = level_r;
    assign rise    = rise_r;
    assign fall    = fall_r;
    assign pending = pending_r;
    assign int_req = int_r;

endmodule
